// File: rtl/garage_gate_sequencer.sv
// rtl/garage_gate_sequencer.sv - entry/exit lane sequencer for the occupancy counter; option macro EXIT_PRIORITY_EN
//
// Two identical lane FSMs share one request arbiter. A lane debounces its
// presence sensor, asks the counter for a door grant, raises the barrier until
// the car passes, then waits for the car to leave the sensor before re-arming.
// EXIT_PRIORITY_EN defined: exit lane wins a simultaneous request.
// EXIT_PRIORITY_EN undefined: entry lane wins a simultaneous request.

module garage_gate_lane #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GRANT_TIMEOUT   = 4,
    parameter int OPEN_CYCLES     = 16,
    parameter int TIMER_W         = 5,
    parameter bit HAS_FULL_HOLD   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic sensor,
    input  logic pass_sensor,
    input  logic open_door,
    input  logic garage_full,
    input  logic arb_grant,
    output logic in_req,
    output logic request,
    output logic gate_up,
    output logic full_lamp,
    output logic timeout_evt
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DEBOUNCE   = 3'd1,
        S_HOLD_FULL  = 3'd2,
        S_REQ        = 3'd3,
        S_WAIT_GRANT = 3'd4,
        S_GATE_UP    = 3'd5,
        S_CLEAR      = 3'd6
    } lane_state_t;

    localparam logic [TIMER_W-1:0] DEB_T   = TIMER_W'(DEBOUNCE_CYCLES);
    localparam logic [TIMER_W-1:0] GRANT_T = TIMER_W'(GRANT_TIMEOUT);
    localparam logic [TIMER_W-1:0] OPEN_T  = TIMER_W'(OPEN_CYCLES);

    lane_state_t        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [TIMER_W-1:0] timer_inc;
    logic               request_q, request_d;
    logic               gate_up_q, gate_up_d;
    logic               full_lamp_q, full_lamp_d;

    // Saturating increment: timers park at all-ones instead of wrapping.
    assign timer_inc = (timer_q == {TIMER_W{1'b1}}) ? timer_q : timer_q + TIMER_W'(1);

    assign in_req    = (state_q == S_REQ);
    assign request   = request_q;
    assign gate_up   = gate_up_q;
    assign full_lamp = full_lamp_q;

    // Next-state, timer and registered-output decode for one lane.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        request_d   = 1'b0;
        gate_up_d   = gate_up_q;
        full_lamp_d = full_lamp_q;
        timeout_evt = 1'b0;
        case (state_q)
            S_IDLE: begin
                gate_up_d   = 1'b0;
                full_lamp_d = 1'b0;
                if (sensor) begin
                    state_d = S_DEBOUNCE;
                    timer_d = TIMER_W'(1);
                end
            end
            S_DEBOUNCE: begin
                if (!sensor) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timer_inc >= DEB_T) begin
                    timer_d = '0;
                    if (HAS_FULL_HOLD && garage_full) begin
                        state_d     = S_HOLD_FULL;
                        full_lamp_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_HOLD_FULL: begin
                full_lamp_d = 1'b1;
                if (!sensor) begin
                    state_d     = S_IDLE;
                    full_lamp_d = 1'b0;
                end else if (!garage_full) begin
                    state_d     = S_REQ;
                    full_lamp_d = 1'b0;
                end
            end
            S_REQ: begin
                // A deferred lane simply waits here with request low.
                if (arb_grant) begin
                    request_d = 1'b1;
                    state_d   = S_WAIT_GRANT;
                    timer_d   = '0;
                end
            end
            S_WAIT_GRANT: begin
                if (open_door) begin
                    state_d   = S_GATE_UP;
                    gate_up_d = 1'b1;
                    timer_d   = '0;
                end else if (timer_inc >= GRANT_T) begin
                    // A refused entry (counter full) ends up here as well.
                    state_d     = S_CLEAR;
                    timeout_evt = 1'b1;
                    timer_d     = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_GATE_UP: begin
                if (pass_sensor || (timer_inc >= OPEN_T)) begin
                    state_d   = S_CLEAR;
                    gate_up_d = 1'b0;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_CLEAR: begin
                // Same car still on the sensor must not trigger a second request.
                gate_up_d = 1'b0;
                if (!sensor) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                timer_d     = '0;
                gate_up_d   = 1'b0;
                full_lamp_d = 1'b0;
            end
        endcase
    end

    // Lane state, timer and outputs; reset drops the barrier immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            request_q   <= 1'b0;
            gate_up_q   <= 1'b0;
            full_lamp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            request_q   <= request_d;
            gate_up_q   <= gate_up_d;
            full_lamp_q <= full_lamp_d;
        end
    end

endmodule

module garage_gate_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GRANT_TIMEOUT   = 4,
    parameter int OPEN_CYCLES     = 16,
    parameter int TIMER_W         = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic entry_sensor,
    input  logic exit_sensor,
    input  logic entry_pass_sensor,
    input  logic exit_pass_sensor,
    input  logic open_entry_door,
    input  logic open_exit_door,
    input  logic garage_is_complete,
    output logic car_entry_request,
    output logic car_exit_request,
    output logic entry_gate_up,
    output logic exit_gate_up,
    output logic full_lamp,
    output logic fault
);

    logic entry_in_req, exit_in_req;
    logic entry_grant, exit_grant;
    logic entry_timeout, exit_timeout;
    logic entry_full_lamp, exit_full_lamp;
    logic fault_q, fault_d;

    // Request arbiter: only one lane may leave REQ per cycle, so the two
    // registered request pulses can never coincide.
    always_comb begin
        entry_grant = 1'b0;
        exit_grant  = 1'b0;
`ifdef EXIT_PRIORITY_EN
        exit_grant  = exit_in_req;
        entry_grant = entry_in_req && !exit_in_req;
`else
        entry_grant = entry_in_req;
        exit_grant  = exit_in_req && !entry_in_req;
`endif
    end

    garage_gate_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .GRANT_TIMEOUT  (GRANT_TIMEOUT),
        .OPEN_CYCLES    (OPEN_CYCLES),
        .TIMER_W        (TIMER_W),
        .HAS_FULL_HOLD  (1'b1)
    ) u_entry_lane (
        .clock      (clock),
        .reset      (reset),
        .sensor     (entry_sensor),
        .pass_sensor(entry_pass_sensor),
        .open_door  (open_entry_door),
        .garage_full(garage_is_complete),
        .arb_grant  (entry_grant),
        .in_req     (entry_in_req),
        .request    (car_entry_request),
        .gate_up    (entry_gate_up),
        .full_lamp  (entry_full_lamp),
        .timeout_evt(entry_timeout)
    );

    garage_gate_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .GRANT_TIMEOUT  (GRANT_TIMEOUT),
        .OPEN_CYCLES    (OPEN_CYCLES),
        .TIMER_W        (TIMER_W),
        .HAS_FULL_HOLD  (1'b0)
    ) u_exit_lane (
        .clock      (clock),
        .reset      (reset),
        .sensor     (exit_sensor),
        .pass_sensor(exit_pass_sensor),
        .open_door  (open_exit_door),
        .garage_full(1'b0),
        .arb_grant  (exit_grant),
        .in_req     (exit_in_req),
        .request    (car_exit_request),
        .gate_up    (exit_gate_up),
        .full_lamp  (exit_full_lamp),
        .timeout_evt(exit_timeout)
    );

    // The exit lane never enters HOLD_FULL, so its lamp stays low; both lanes
    // are OR-ed so the lamp logic stays symmetric with the lane module.
    assign full_lamp = entry_full_lamp | exit_full_lamp;
    assign fault     = fault_q;

    // Sticky fault: any grant timeout latches it until reset.
    always_comb begin
        fault_d = fault_q | entry_timeout | exit_timeout;
    end

    // Fault flag register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_garage_gate_sequencer.sv
// tb/tb_garage_gate_sequencer.sv - directed self-checking bench for garage_gate_sequencer

module tb_garage_gate_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic entry_sensor = 1'b0, exit_sensor = 1'b0;
    logic entry_pass_sensor = 1'b0, exit_pass_sensor = 1'b0;
    logic open_entry_door = 1'b0, open_exit_door = 1'b0;
    logic garage_is_complete = 1'b0;
    logic car_entry_request, car_exit_request;
    logic entry_gate_up, exit_gate_up, full_lamp, fault;
    logic [5:0] outs;

    int n_cmp = 0;
    int n_err = 0;

`ifdef EXIT_PRIORITY_EN
    localparam bit EXIT_FIRST = 1'b1;
`else
    localparam bit EXIT_FIRST = 1'b0;
`endif

    // {entry_req, exit_req, entry_gate, exit_gate, full_lamp, fault}
    assign outs = {car_entry_request, car_exit_request, entry_gate_up, exit_gate_up, full_lamp, fault};

    always #5 clock = ~clock;

    garage_gate_sequencer dut (
        .clock             (clock),
        .reset             (reset),
        .entry_sensor      (entry_sensor),
        .exit_sensor       (exit_sensor),
        .entry_pass_sensor (entry_pass_sensor),
        .exit_pass_sensor  (exit_pass_sensor),
        .open_entry_door   (open_entry_door),
        .open_exit_door    (open_exit_door),
        .garage_is_complete(garage_is_complete),
        .car_entry_request (car_entry_request),
        .car_exit_request  (car_exit_request),
        .entry_gate_up     (entry_gate_up),
        .exit_gate_up      (exit_gate_up),
        .full_lamp         (full_lamp),
        .fault             (fault)
    );

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        entry_sensor = 1'b0; exit_sensor = 1'b0;
        entry_pass_sensor = 1'b0; exit_pass_sensor = 1'b0;
        open_entry_door = 1'b0; open_exit_door = 1'b0;
        garage_is_complete = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL reset_outputs got=%b exp=%b", outs, 6'b000000); end
        tick();
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL reset_idle got=%b exp=%b", outs, 6'b000000); end
    endtask

    task automatic test_entry_pass();
        do_reset();
        entry_sensor = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL entry_pass debounce%0d got=%b exp=%b", i, outs, 6'b000000); end
        end
        tick();
        n_cmp++; if (outs !== 6'b100000) begin n_err++; $display("FAIL entry_pass request got=%b exp=%b", outs, 6'b100000); end
        tick();
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL entry_pass req_one_cycle got=%b exp=%b", outs, 6'b000000); end
        open_entry_door = 1'b1;
        tick();
        n_cmp++; if (outs !== 6'b001000) begin n_err++; $display("FAIL entry_pass gate_up got=%b exp=%b", outs, 6'b001000); end
        open_entry_door = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (outs !== 6'b001000) begin n_err++; $display("FAIL entry_pass gate_hold%0d got=%b exp=%b", i, outs, 6'b001000); end
        end
        entry_pass_sensor = 1'b1;
        entry_sensor = 1'b0;
        tick();
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL entry_pass gate_down got=%b exp=%b", outs, 6'b000000); end
        entry_pass_sensor = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL entry_pass idle%0d got=%b exp=%b", i, outs, 6'b000000); end
        end
    endtask

    task automatic test_short_pulse();
        do_reset();
        entry_sensor = 1'b1;
        tick();
        tick();
        entry_sensor = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL short_pulse no_req%0d got=%b exp=%b", i, outs, 6'b000000); end
        end
        // Fresh debounce from IDLE still takes the full four samples.
        entry_sensor = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL short_pulse redebounce%0d got=%b exp=%b", i, outs, 6'b000000); end
        end
        tick();
        n_cmp++; if (outs !== 6'b100000) begin n_err++; $display("FAIL short_pulse request got=%b exp=%b", outs, 6'b100000); end
    endtask

    task automatic test_full_hold();
        do_reset();
        garage_is_complete = 1'b1;
        entry_sensor = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL full_hold debounce%0d got=%b exp=%b", i, outs, 6'b000000); end
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (outs !== 6'b000010) begin n_err++; $display("FAIL full_hold lamp%0d got=%b exp=%b", i, outs, 6'b000010); end
        end
        garage_is_complete = 1'b0;
        tick();
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL full_hold lamp_off got=%b exp=%b", outs, 6'b000000); end
        tick();
        n_cmp++; if (outs !== 6'b100000) begin n_err++; $display("FAIL full_hold request got=%b exp=%b", outs, 6'b100000); end
        tick();
        open_entry_door = 1'b1;
        tick();
        n_cmp++; if (outs !== 6'b001000) begin n_err++; $display("FAIL full_hold gate_up got=%b exp=%b", outs, 6'b001000); end
        open_entry_door = 1'b0;
        entry_pass_sensor = 1'b1;
        entry_sensor = 1'b0;
        tick();
        entry_pass_sensor = 1'b0;
        tick();
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL full_hold done got=%b exp=%b", outs, 6'b000000); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] first_req, second_req, first_gate;
        first_req  = EXIT_FIRST ? 6'b010000 : 6'b100000;
        second_req = EXIT_FIRST ? 6'b100000 : 6'b010000;
        first_gate = EXIT_FIRST ? 6'b000100 : 6'b001000;
        do_reset();
        entry_sensor = 1'b1;
        exit_sensor = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL back_to_back debounce%0d got=%b exp=%b", i, outs, 6'b000000); end
        end
        tick();
        n_cmp++; if (outs !== first_req) begin n_err++; $display("FAIL back_to_back first_req got=%b exp=%b", outs, first_req); end
        tick();
        n_cmp++; if (outs !== second_req) begin n_err++; $display("FAIL back_to_back second_req got=%b exp=%b", outs, second_req); end
        if (EXIT_FIRST) open_exit_door = 1'b1; else open_entry_door = 1'b1;
        tick();
        n_cmp++; if (outs !== first_gate) begin n_err++; $display("FAIL back_to_back first_gate got=%b exp=%b", outs, first_gate); end
        open_exit_door = ~open_exit_door;
        open_entry_door = ~open_entry_door;
        tick();
        n_cmp++; if (outs !== 6'b001100) begin n_err++; $display("FAIL back_to_back both_gates got=%b exp=%b", outs, 6'b001100); end
        open_exit_door = 1'b0;
        open_entry_door = 1'b0;
        entry_pass_sensor = 1'b1; exit_pass_sensor = 1'b1;
        entry_sensor = 1'b0; exit_sensor = 1'b0;
        tick();
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL back_to_back gates_down got=%b exp=%b", outs, 6'b000000); end
        entry_pass_sensor = 1'b0; exit_pass_sensor = 1'b0;
        tick();
    endtask

    task automatic test_grant_timeout();
        do_reset();
        entry_sensor = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tick();
        n_cmp++; if (outs !== 6'b100000) begin n_err++; $display("FAIL grant_timeout request got=%b exp=%b", outs, 6'b100000); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL grant_timeout waiting%0d got=%b exp=%b", i, outs, 6'b000000); end
        end
        tick();
        n_cmp++; if (outs !== 6'b000001) begin n_err++; $display("FAIL grant_timeout fault got=%b exp=%b", outs, 6'b000001); end
        // Late grant while in CLEAR must be ignored.
        open_entry_door = 1'b1;
        tick();
        n_cmp++; if (outs !== 6'b000001) begin n_err++; $display("FAIL grant_timeout late_grant got=%b exp=%b", outs, 6'b000001); end
        open_entry_door = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (outs !== 6'b000001) begin n_err++; $display("FAIL grant_timeout clear_hold%0d got=%b exp=%b", i, outs, 6'b000001); end
        end
        entry_sensor = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (outs !== 6'b000001) begin n_err++; $display("FAIL grant_timeout sticky%0d got=%b exp=%b", i, outs, 6'b000001); end
        end
    endtask

    task automatic test_gate_timeout();
        do_reset();
        entry_sensor = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        tick();
        open_entry_door = 1'b1;
        tick();
        open_entry_door = 1'b0;
        n_cmp++; if (outs !== 6'b001000) begin n_err++; $display("FAIL gate_timeout gate_up got=%b exp=%b", outs, 6'b001000); end
        for (int i = 2; i <= 16; i++) begin
            tick();
            n_cmp++; if (outs !== 6'b001000) begin n_err++; $display("FAIL gate_timeout held_cycle%0d got=%b exp=%b", i, outs, 6'b001000); end
        end
        tick();
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL gate_timeout dropped got=%b exp=%b", outs, 6'b000000); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL gate_timeout no_rereq%0d got=%b exp=%b", i, outs, 6'b000000); end
        end
    endtask

    task automatic test_reset_gate_up();
        do_reset();
        exit_sensor = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tick();
        n_cmp++; if (outs !== 6'b010000) begin n_err++; $display("FAIL reset_gate exit_request got=%b exp=%b", outs, 6'b010000); end
        tick();
        open_exit_door = 1'b1;
        tick();
        open_exit_door = 1'b0;
        n_cmp++; if (outs !== 6'b000100) begin n_err++; $display("FAIL reset_gate exit_gate_up got=%b exp=%b", outs, 6'b000100); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL reset_gate async_drop got=%b exp=%b", outs, 6'b000000); end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++; if (outs !== 6'b000000) begin n_err++; $display("FAIL reset_gate fresh_debounce%0d got=%b exp=%b", i, outs, 6'b000000); end
        end
        tick();
        n_cmp++; if (outs !== 6'b010000) begin n_err++; $display("FAIL reset_gate re_request got=%b exp=%b", outs, 6'b010000); end
    endtask

    initial begin
        test_reset();
        test_entry_pass();
        test_short_pulse();
        test_full_hold();
        test_back_to_back();
        test_grant_timeout();
        test_gate_timeout();
        test_reset_gate_up();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
